// File: rtl/ws2812b_tx.sv
// WS2812B serial transmitter: 8 LEDs x 12-bit GRB, NRZ timing at 100 MHz.
// Define WS_FULL_SCALE_EN to expand nibble n to {n,n}; default is {0,n}.
module ws2812b_tx #(
    parameter int T0H    = 40,
    parameter int T1H    = 80,
    parameter int TBIT   = 125,
    parameter int TLATCH = 5000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        dataOut,
    output logic        busy,
    output logic        frameDone,
    input  logic        go,
    input  logic [95:0] regVal
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } stateT;

    localparam logic [12:0] t0hLast    = 13'(T0H - 1);
    localparam logic [12:0] t1hLast    = 13'(T1H - 1);
    localparam logic [12:0] tbitLast   = 13'(TBIT - 1);
    localparam logic [12:0] tlatchLast = 13'(TLATCH - 1);
    localparam logic [12:0] tlatchPre  = 13'(TLATCH - 2);
    localparam logic [7:0]  lastBit    = 8'd191;

    stateT        state;
    logic [191:0] shiftReg;
    logic [7:0]   bitCnt;
    logic [12:0]  cycCnt;

    function automatic logic [191:0] expandFrame(input logic [95:0] r);
        logic [191:0] e;
        logic [3:0]   n;
        e = '0;
        for (int i = 0; i < 24; i++) begin
            n = r[95 - 4*i -: 4];
`ifdef WS_FULL_SCALE_EN
            e[191 - 8*i -: 8] = {n, n};
`else
            e[191 - 8*i -: 8] = {4'b0000, n};
`endif
        end
        return e;
    endfunction

    // Frame sequencer: high phase, low phase per bit, then latch low period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shiftReg  <= '0;
            bitCnt    <= '0;
            cycCnt    <= '0;
            dataOut   <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    frameDone <= 1'b0;
                    if (go) begin
                        shiftReg <= expandFrame(regVal);
                        bitCnt   <= '0;
                        cycCnt   <= '0;
                        dataOut  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    cycCnt <= cycCnt + 13'd1;
                    if (cycCnt == (shiftReg[191] ? t1hLast : t0hLast)) begin
                        dataOut <= 1'b0;
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (cycCnt == tbitLast) begin
                        cycCnt <= '0;
                        if (bitCnt == lastBit) begin
                            state <= LATCH;
                        end else begin
                            shiftReg <= {shiftReg[190:0], 1'b0};
                            bitCnt   <= bitCnt + 8'd1;
                            dataOut  <= 1'b1;
                            state    <= HIGH;
                        end
                    end else begin
                        cycCnt <= cycCnt + 13'd1;
                    end
                end
                LATCH: begin
                    if (cycCnt == tlatchLast) begin
                        cycCnt    <= '0;
                        busy      <= 1'b0;
                        frameDone <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cycCnt    <= cycCnt + 13'd1;
                        frameDone <= (cycCnt == tlatchPre);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_tx.sv
// Directed bench for ws2812b_tx: decodes the NRZ waveform and checks
// bit timing, frame length, nibble expansion, back-to-back and reset.
module tb_ws2812b_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic [95:0] regVal = '0;
    logic        dataOut;
    logic        busy;
    logic        frameDone;

    int checks = 0;
    int fails = 0;

    logic [191:0] bits;
    logic [191:0] expFrame;
    int           total;
    int           bad;

`ifdef WS_FULL_SCALE_EN
    localparam logic [23:0] expFFF24 = 24'hFFFFFF;
    localparam logic [23:0] expA5C   = 24'hAA55CC;
    localparam logic [47:0] expCAB48 = 48'hCCAABBFFAADD;
`else
    localparam logic [23:0] expFFF24 = 24'h0F0F0F;
    localparam logic [23:0] expA5C   = 24'h0A050C;
    localparam logic [47:0] expCAB48 = 48'h0C0A0B0F0A0D;
`endif

    ws2812b_tx dut (
        .clk      (clk),
        .reset    (reset),
        .dataOut  (dataOut),
        .busy     (busy),
        .frameDone(frameDone),
        .go       (go),
        .regVal   (regVal)
    );

    always #5 clk = ~clk;

    function automatic logic [191:0] expand(input logic [95:0] r);
        logic [191:0] e;
        logic [3:0]   n;
        e = '0;
        for (int i = 0; i < 24; i++) begin
            n = r[95 - 4*i -: 4];
`ifdef WS_FULL_SCALE_EN
            e[191 - 8*i -: 8] = {n, n};
`else
            e[191 - 8*i -: 8] = {4'h0, n};
`endif
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decode n bits starting at the first high cycle; for the last bit
    // the low phase runs through the latch up to the frameDone cycle.
    task automatic recvBits(input int n, output logic [191:0] b192,
                            output int tot, output int nBad);
        int w;
        int hi;
        int lo;
        b192 = '0;
        tot = 0;
        nBad = 0;
        w = 0;
        while (dataOut !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (dataOut !== 1'b1) begin
            nBad = 1000;
            return;
        end
        for (int b = 0; b < n; b++) begin
            hi = 0;
            while (dataOut === 1'b1 && hi < 200) begin
                hi++;
                tot++;
                @(negedge clk);
            end
            b192[191 - b] = (hi == 80);
            if (hi != 40 && hi != 80) nBad++;
            lo = 0;
            if (b < 191) begin
                while (dataOut === 1'b0 && lo < 200) begin
                    lo++;
                    tot++;
                    @(negedge clk);
                end
                if (hi + lo != 125) nBad++;
            end else begin
                while (frameDone !== 1'b1 && dataOut === 1'b0 && lo < 6000) begin
                    lo++;
                    tot++;
                    @(negedge clk);
                end
                tot++;
                if (hi + lo != 125 + 4999) nBad++;
            end
        end
    endtask

    initial begin
        // Reset held with go high: nothing moves
        reset = 1'b0;
        go = 1'b1;
        regVal = 96'hFFF000FFF000FFF000FFF000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_dataOut", dataOut, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frameDone", frameDone, 0);
        end
        go = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_dataOut", dataOut, 0);

        // Single frame, one-cycle go, go toggled during frame and latch
        regVal = 96'hFFF000FFF000FFF000FFF000;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("lat_dataOut", dataOut, 1);
        chk("lat_busy", busy, 1);
        fork
            recvBits(192, bits, total, bad);
            begin
                for (int k = 0; k < 28; k++) begin
                    repeat (1000) @(negedge clk);
                    go = ~go;
                end
            end
        join
        expFrame = expand(96'hFFF000FFF000FFF000FFF000);
        chk("f1_total", total, 29000);
        chk("f1_timing", bad, 0);
        chk("f1_bits", bits, expFrame);
        chk("f1_first24", bits[191:168], expFFF24);
        chk("f1_frameDone", frameDone, 1);
        chk("f1_busy_end", busy, 1);
        @(negedge clk);
        chk("f1_busy_fall", busy, 0);
        chk("f1_done_pulse", frameDone, 0);
        repeat (20) @(negedge clk);
        chk("f1_no_restart_d", dataOut, 0);
        chk("f1_no_restart_b", busy, 0);

        // Expansion frame, reset during high phase of bit 100
        regVal = {12'hA5C, 84'h123456789ABCDEF012345};
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        recvBits(100, bits, total, bad);
        expFrame = expand({12'hA5C, 84'h123456789ABCDEF012345});
        chk("ex_timing", bad, 0);
        chk("ex_total", total, 12500);
        chk("ex_first24", bits[191:168], expA5C);
        chk("ex_100bits", bits[191:92], expFrame[191:92]);
        repeat (10) @(negedge clk);
        chk("b100_high", dataOut, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_dataOut", dataOut, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frameDone", frameDone, 0);
        @(negedge clk);
        chk("mid_rst_hold", dataOut, 0);

        // Back-to-back with go held, regVal changed mid-frame
        regVal = 96'hBEEDADBEEDADBEEDADBEEDAD;
        go = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("b2b_start_d", dataOut, 1);
        chk("b2b_start_b", busy, 1);
        fork
            recvBits(192, bits, total, bad);
            begin
                repeat (50 * 125) @(negedge clk);
                regVal = 96'hCABFADCABFADCABFADCABFAD;
            end
        join
        expFrame = expand(96'hBEEDADBEEDADBEEDADBEEDAD);
        chk("b2b_f1_total", total, 29000);
        chk("b2b_f1_timing", bad, 0);
        chk("b2b_f1_bits", bits, expFrame);
        chk("b2b_f1_done", frameDone, 1);
        @(negedge clk);
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_data", dataOut, 0);
        @(negedge clk);
        chk("b2b_f2_busy", busy, 1);
        chk("b2b_f2_data", dataOut, 1);
        go = 1'b0;
        recvBits(48, bits, total, bad);
        expFrame = expand(96'hCABFADCABFADCABFADCABFAD);
        chk("b2b_f2_timing", bad, 0);
        chk("b2b_f2_48", bits[191:144], expCAB48);
        chk("b2b_f2_model", bits[191:144], expFrame[191:144]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/ws2812b_tx.md
# ws2812b_tx

Serial transmitter for the WS2812B LED strip: the consuming end of the `go`/`regVal` interface driven by the mode state machine. On `go` it captures the 96-bit frame (8 LEDs × 12-bit GRB, 4 bits per colour) and expands each nibble to a byte. It then shifts 192 bits out on `dataOut` with WS2812B NRZ pulse timing at 100 MHz, and finishes with the strip latch (reset) low period. It sits between the mode machine and the board pin driving the strip.

## Interface
- `T0H`, 40: high cycles for a 0 bit (0.40 µs).
- `T1H`, 80: high cycles for a 1 bit (0.80 µs).
- `TBIT`, 125: total cycles per bit (1.25 µs); must exceed `T1H`.
- `TLATCH`, 5000: low cycles after the last bit (50 µs).
- `clk`  input  1  100 MHz system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `dataOut`  output  1  serial line to strip DIN, registered.
- `busy`  output  1  high while a frame or its latch is in progress.
- `frameDone`  output  1  one-cycle pulse on the final latch cycle.
- `go`  input  1  frame request, level-sampled in IDLE.
- `regVal`  input  96  frame data; `[95:84]` = LED0 (sent first); within each 12-bit group `[11:8]`=G, `[7:4]`=R, `[3:0]`=B.

## Operation
- States: IDLE, HIGH, LOW, LATCH.
- IDLE, on `go`=1:
  - Load the 192-bit shift register from `regVal` with nibble expansion.
  - Clear the bit counter (8-bit, 0..191) and the cycle counter (13-bit).
  - Enter HIGH.
- HIGH: hold `dataOut`=1 for `T1H` cycles if the current MSB is 1, else `T0H` cycles; then enter LOW.
- LOW: hold `dataOut`=0 until the bit totals `TBIT` cycles.
  - Bit counter < 191: shift left one bit, increment the bit counter, enter HIGH.
  - Bit counter = 191: enter LATCH.
- LATCH: `dataOut`=0 for `TLATCH` cycles.
  - `frameDone`=1 on the last cycle.
  - Next state is IDLE; if `go` is already 1 in IDLE, the next frame starts without an extra gap.
- Send order: G byte, R byte, B byte per LED, MSB first; LED0 through LED7.
- `regVal` and `go` are ignored outside IDLE. The captured frame is immune to mid-frame changes on `regVal`.
- Reset (any time, including mid-bit):
  - `dataOut`=0, `busy`=0, `frameDone`=0.
  - State returns to IDLE; counters and shift register are cleared.
  - After release, the first `go` starts a fresh frame. The strip sees the truncated frame plus idle low as a latch.

## Timing
- Reset values: `dataOut`=0, `busy`=0, `frameDone`=0.
- Latency: `go` sampled high at edge N in IDLE → `dataOut`=1 and `busy`=1 from edge N+1.
- Bit period: exactly `TBIT` cycles, with no jitter between bits.
- Frame length: 192×`TBIT` + `TLATCH` = 29000 cycles from edge N+1 through the `frameDone` cycle.
- `busy` falls in the same edge IDLE is re-entered. With `go` held high, `busy` stays low for exactly 1 cycle (the IDLE sampling cycle) between frames.
- All outputs are registered; nothing is combinational from inputs.

## Configuration
- `WS_FULL_SCALE_EN`:
  - Defined: each nibble n expands to byte `{n,n}` (0xF→0xFF, 0xA→0xAA), giving full-scale brightness.
  - Undefined: byte is `{4'b0000,n}` (0xA→0x0A), giving dim output.
- Timing and framing are identical in both builds.

## Test plan
- Reset: hold `reset`=0 with `go`=1 and toggling `clk` → `dataOut`=0, `busy`=0, `frameDone`=0 throughout. No frame starts until `reset`=1.
- Single frame, `regVal`=96'hFFF_000_FFF_000_FFF_000_FFF_000, one-cycle `go` pulse:
  - First 24 bits are 1s, each 80 high / 45 low.
  - Next 24 bits are 0s, each 40 high / 85 low.
  - Total 192 high pulses, then 5000 low cycles.
  - `frameDone` pulses on cycle 29000 after `dataOut` first rises; `busy` then falls.
- Expansion, `regVal[95:84]`=12'hA5C:
  - With `WS_FULL_SCALE_EN`: first 24 decoded bits are 0xAA,0x55,0xCC.
  - Without it: 0x0A,0x05,0x0C.
- Back-to-back: hold `go`=1 with `regVal`=96'hBEE_DAD_BEE_DAD_BEE_DAD_BEE_DAD; change `regVal` to 96'hCAB_FAD_CAB_FAD_CAB_FAD_CAB_FAD at bit 50 of frame 1.
  - Frame 1 decodes entirely as BEEDAD.
  - Frame 2 starts 1 cycle after `frameDone` (`busy` low exactly 1 cycle) and decodes CABFAD.
- Reset mid-frame: assert `reset`=0 during a HIGH phase of bit 100 → `dataOut`=0 asynchronously, `busy`=0. After release, a new `go` yields a full 192-bit frame from bit 0.
- Ignored `go`: toggle `go` during a frame and during LATCH → no restart; the frame still takes exactly 29000 cycles.
